// File: rtl/bit_serializer.sv
// bit_serializer
// ---------------------------------------------------------------------------
// Parallel-to-serial front end for a serial sequence detector. Words enter
// through a valid/ready load port into a one-word holding buffer. A shift
// engine emits each word one bit per enabled clock. While one frame is
// shifting, the buffer lets the next word wait, so consecutive words stream
// with no gap bits between them.
//
// Handshake: a word transfers on a rising edge where load_valid && load_ready.
// load_ready is !hold_full, so it comes from a register only and never depends
// combinationally on load_valid. While load_ready is low, load_valid and
// load_data are ignored.
//
// Ports:
//   clk          system clock; all logic updates on the rising edge
//   rst          synchronous, active-high reset
//   bit_en       bit-rate enable; the shift engine advances only when high
//   load_valid   load_data is valid this cycle
//   load_data    WIDTH-bit word to serialize
//   load_ready   holding buffer is empty and can accept a word
//   ser_out      serial bit stream (IDLE_BIT when no frame is shifting)
//   ser_valid    ser_out carries a frame bit
//   frame_start  high while the first bit of a frame is on ser_out
//   busy         a frame is shifting or the holding buffer is occupied
//   frame_count  number of words started, wrapping modulo 256
// ---------------------------------------------------------------------------
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy,
  output logic [7:0]       frame_count
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // State and its next value. state stays visible at this level so checkers
  // can bind to it directly.
  state_t           state, state_nxt;
  logic [WIDTH-1:0] hold_reg, hold_reg_nxt;
  logic             hold_full, hold_full_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]       frame_cnt, frame_cnt_nxt;

  logic accept;
  logic take;
  logic last_bit;

  assign last_bit = (bit_cnt == LAST);

  // Accept needs an empty buffer and take needs a full one, so the two can
  // never occur on the same edge. That is why the buffer needs no bypass path.
  assign accept = load_valid && !hold_full;

  // A buffered word moves into the shifter either from IDLE, or on the edge
  // that retires the last bit of the current frame. The second case is what
  // gives gapless back-to-back frames.
  assign take = bit_en && hold_full && ((state == IDLE) || last_bit);

  // Next-state and datapath decode.
  always_comb begin
    state_nxt     = state;
    hold_reg_nxt  = hold_reg;
    hold_full_nxt = hold_full;
    shreg_nxt     = shreg;
    bit_cnt_nxt   = bit_cnt;
    frame_cnt_nxt = frame_cnt;

    if (accept) begin
      hold_reg_nxt  = load_data;
      hold_full_nxt = 1'b1;
    end

    if (take) begin
      shreg_nxt     = hold_reg;
      bit_cnt_nxt   = '0;
      state_nxt     = SHIFT;
      hold_full_nxt = 1'b0;
      frame_cnt_nxt = frame_cnt + 8'd1;
    end else if (bit_en && (state == SHIFT)) begin
      if (!last_bit) begin
        // Move the next bit into the output position.
        if (MSB_FIRST) begin
          shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
        end else begin
          shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
        end
        bit_cnt_nxt = bit_cnt + CW'(1);
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  // State register. A reset drops both the in-flight word and the buffered
  // word. The hold data register is also cleared, so its contents are
  // deterministic after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      frame_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      hold_reg  <= hold_reg_nxt;
      hold_full <= hold_full_nxt;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      frame_cnt <= frame_cnt_nxt;
    end
  end

  // Output decode. Every output comes from registered state only.
  assign load_ready  = !hold_full;
  assign ser_valid   = (state == SHIFT);
  assign ser_out     = (state == SHIFT) ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0])
                                        : IDLE_BIT;
  assign frame_start = (state == SHIFT) && (bit_cnt == '0);
  assign busy        = (state == SHIFT) || hold_full;
  assign frame_count = frame_cnt;

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer
// ---------------------------------------------------------------------------
// Self-checking bench for bit_serializer (WIDTH=8, MSB_FIRST=1, IDLE_BIT=0).
//
// Reference model: an optional one-word buffer plus a queue of the bits still
// to be shown for the current frame. On each enabled edge the shown bit is
// retired. If the frame has run out and a word is buffered, that word's bits
// are queued. The compare process checks every output against this model on
// each falling edge. The directed tests also pin the captured serial stream
// to hand-computed literals.
// ---------------------------------------------------------------------------
module tb_bit_serializer;

  localparam int W = 8;
  localparam bit MSB_FIRST = 1'b1;
  localparam bit IDLE_BIT  = 1'b0;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         bit_en;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         frame_start;
  logic         busy;
  logic [7:0]   frame_count;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(MSB_FIRST), .IDLE_BIT(IDLE_BIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bit_en      (bit_en),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .frame_start (frame_start),
    .busy        (busy),
    .frame_count (frame_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model (scoreboard)
  // -------------------------------------------------------------------------
  logic [0:0]   exp_q[$];     // bits of the current frame still to appear
  logic [W-1:0] m_buf;
  bit           m_full;
  logic [7:0]   m_cnt;
  int           m_start_size; // size the queue had when the frame began
  bit           live = 1'b0;

  always @(posedge clk) begin
    bit pre_full;
    if (rst) begin
      exp_q.delete();
      m_full = 1'b0;
      m_cnt  = 8'd0;
      live   = 1'b1;
    end else if (live) begin
      pre_full = m_full;
      if (bit_en && exp_q.size() > 0) void'(exp_q.pop_front());
      if (bit_en && pre_full && exp_q.size() == 0) begin
        for (int i = 0; i < W; i++)
          exp_q.push_back(MSB_FIRST ? m_buf[W-1-i] : m_buf[i]);
        m_full = 1'b0;
        m_cnt  = m_cnt + 8'd1;
      end
      if (load_valid && !pre_full) begin
        m_buf  = load_data;
        m_full = 1'b1;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (live) begin
      bit ev;
      ev = (exp_q.size() > 0);
      chk("ser_valid", {31'd0, ser_valid}, {31'd0, ev});
      chk("ser_out", {31'd0, ser_out}, {31'd0, ev ? exp_q[0] : IDLE_BIT});
      chk("frame_start", {31'd0, frame_start}, {31'd0, ev && exp_q.size() == W});
      chk("load_ready", {31'd0, load_ready}, {31'd0, !m_full});
      chk("busy", {31'd0, busy}, {31'd0, ev || m_full});
      chk("frame_count", {24'd0, frame_count}, {24'd0, m_cnt});
    end
  end

  // -------------------------------------------------------------------------
  // Stream capture for the directed literal checks
  // -------------------------------------------------------------------------
  logic [31:0] acc;
  int          vcycles, runs, fs_cnt, det_cnt;
  logic [2:0]  hist;
  logic        prev_valid;

  task automatic clear_rx();
    acc = '0; vcycles = 0; runs = 0; fs_cnt = 0; det_cnt = 0;
    hist = '0; prev_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (live && !rst) begin
      if (ser_valid) begin
        acc = {acc[30:0], ser_out};
        vcycles++;
        if (!prev_valid) runs++;
        if (frame_start) fs_cnt++;
        hist = {hist[1:0], ser_out};
        if (vcycles >= 3 && hist == 3'b110) det_cnt++;
      end
      prev_valid = ser_valid;
    end
  end

  // -------------------------------------------------------------------------
  // Drivers
  // -------------------------------------------------------------------------
  bit en_mode = 1'b0; // 0: bit_en held high, 1: bit_en toggles every cycle

  initial begin
    bit_en = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (en_mode) bit_en = !bit_en;
      else         bit_en = 1'b1;
    end
  end

  // Presents d until it is accepted, then leaves the bench at #1 after the
  // accepting edge with load_valid low.
  task automatic load_word(input logic [W-1:0] d);
    int n;
    logic r;
    n = 0;
    load_valid = 1'b1;
    load_data  = d;
    do begin
      @(negedge clk); r = load_ready;
      @(posedge clk); #1;
      n++;
    end while (!r && n < 200);
    chk("load_accept_timeout", {31'd0, r}, 32'd1);
    load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (busy && n < 1000);
    chk("idle_timeout", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  // -------------------------------------------------------------------------
  // Directed tests
  // -------------------------------------------------------------------------
  initial begin
    int n;
    rst = 1'b1; load_valid = 1'b0; load_data = '0;
    clear_rx();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
    chk("rst_ser_valid", {31'd0, ser_valid}, 32'd0);
    chk("rst_ser_out", {31'd0, ser_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_count", {24'd0, frame_count}, 32'd0);
    @(posedge clk); #1;

    // T1: single word 8'hD6.
    clear_rx();
    load_word(8'hD6);
    wait_idle();
    chk("t1_stream", {24'd0, acc[7:0]}, 32'hD6);
    chk("t1_vcycles", vcycles, 8);
    chk("t1_runs", runs, 1);
    chk("t1_frame_start", fs_cnt, 1);
    chk("t1_frame_count", {24'd0, frame_count}, 32'd1);

    // T2/T3: back-to-back C0, 06, then FF presented while the buffer is full.
    clear_rx();
    load_word(8'hC0);
    load_word(8'h06);
    chk("t2_ready_low", {31'd0, load_ready}, 32'd0);
    load_valid = 1'b1; load_data = 8'hFF;
    repeat (3) begin @(posedge clk); #1; end
    load_valid = 1'b0;
    wait_idle();
    chk("t2_stream", {16'd0, acc[15:0]}, 32'hC006);
    chk("t2_vcycles", vcycles, 16);
    chk("t2_runs", runs, 1);
    chk("t2_det110", det_cnt, 2);
    chk("t3_not_captured_count", {24'd0, frame_count}, 32'd3);
    clear_rx();
    load_word(8'hFF);
    wait_idle();
    chk("t3_stream", {24'd0, acc[7:0]}, 32'hFF);
    chk("t3_vcycles", vcycles, 8);

    // T4: bit_en toggling, so each bit of A5 is held for two cycles.
    clear_rx();
    en_mode = 1'b1;
    load_word(8'hA5);
    wait_idle();
    en_mode = 1'b0;
    @(posedge clk); #1;
    chk("t4_stream", {16'd0, acc[15:0]}, 32'hCC33);
    chk("t4_vcycles", vcycles, 16);
    chk("t4_runs", runs, 1);

    // T5: reset mid-frame with a word buffered.
    clear_rx();
    load_word(8'hD6);
    load_word(8'h3C);
    n = 0;
    while (vcycles < 4 && n < 100) begin @(negedge clk); n++; end
    chk("t5_reach_bit4", {31'd0, vcycles >= 4}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_ser_valid", {31'd0, ser_valid}, 32'd0);
    chk("t5_ser_out", {31'd0, ser_out}, 32'd0);
    chk("t5_load_ready", {31'd0, load_ready}, 32'd1);
    chk("t5_frame_count", {24'd0, frame_count}, 32'd0);
    clear_rx();
    repeat (20) @(negedge clk);
    chk("t5_no_bits", vcycles, 0);
    @(posedge clk); #1;

    // T6: 257 words, so frame_count wraps through 0 and ends at 1.
    for (int i = 0; i < 257; i++) load_word(i[7:0] ^ 8'h5A);
    wait_idle();
    chk("t6_frame_count", {24'd0, frame_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
